// File: rtl/image_feeder.sv
// image_feeder: source side of the EPU line-window buffer.
// Walks the image with stride 1 (left to right, then down one row per band)
// and reads each window's pixels from the image SRAM in column-major order.
// Each pixel is forwarded to the window buffer with a per-pixel write strobe.
// For 5x5 windows, a horizontal step shifts the buffer and reloads only the
// new right-hand column. 4x4 windows are always fully reloaded.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_start                    start pulse (IDLE only)
//   i_mode, i_img_w/h, i_base_addr
//                              frame config, captured at start
//   o_mem_en, o_mem_addr       SRAM read request
//   i_mem_rdata                SRAM data, one cycle after o_mem_en
//   o_image, o_image_new_*     pixel and its load strobe
//   o_conv_done                buffer shift pulse
//   o_win_valid, i_win_done    window handshake with the conv engine
//   o_busy, o_done             status
module image_feeder #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [DIM_W-1:0]  i_img_w,
  input  logic [DIM_W-1:0]  i_img_h,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_rdata,
  output logic [7:0]        o_image,
  output logic              o_image_new_25,
  output logic              o_image_new_5,
  output logic              o_image_new_16,
  output logic              o_conv_done,
  output logic              o_win_valid,
  input  logic              i_win_done,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_FULL, WAIT_CONV, SHIFT, LOAD_COL, FIN
  } state_t;

  state_t            r_state;
  logic              r_k5;
  logic [DIM_W-1:0]  r_img_w, r_img_h;
  logic [ADDR_W-1:0] r_base;
  logic [DIM_W-1:0]  r_row0, r_col0;
  // (r_r, r_c): window-relative position of the read currently on o_mem_addr
  logic [DIM_W-1:0]  r_r, r_c;
  logic [7:0]        r_img;

  logic [DIM_W-1:0]  w_k, w_km1, w_k_in;
  logic [DIM_W-1:0]  w_nr, w_nc;
  logic              w_last_rd, w_last_col, w_last_row, w_strb;

  function automatic logic [ADDR_W-1:0] f_addr(
    input logic [ADDR_W-1:0] base,
    input logic [DIM_W-1:0]  w,
    input logic [DIM_W-1:0]  row,
    input logic [DIM_W-1:0]  col
  );
    logic [2*DIM_W-1:0] prod;
    prod = row * w;
    return base + ADDR_W'(prod) + ADDR_W'(col);
  endfunction

  assign w_k    = r_k5 ? DIM_W'(5) : DIM_W'(4);
  assign w_km1  = w_k - DIM_W'(1);
  assign w_k_in = i_mode ? DIM_W'(4) : DIM_W'(5);

  // A column reload finishes after row 4; a full load at the bottom-right pixel.
  assign w_last_rd = (r_state == LOAD_COL) ? (r_r == DIM_W'(4))
                                           : (r_r == w_km1 && r_c == w_km1);
  // Column-major walk; in LOAD_COL r_c stays pinned to the new column.
  assign w_nr = (r_r == w_km1) ? '0 : r_r + DIM_W'(1);
  assign w_nc = (r_r == w_km1) ? r_c + DIM_W'(1) : r_c;

  assign w_last_col = (r_col0 == r_img_w - w_k);
  assign w_last_row = (r_row0 == r_img_h - w_k);

  // SRAM data lands in the strobe cycle; hold the last pixel otherwise.
  assign w_strb  = o_image_new_25 | o_image_new_5 | o_image_new_16;
  assign o_image = w_strb ? i_mem_rdata : r_img;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_k5           <= 1'b0;
      r_img_w        <= '0;
      r_img_h        <= '0;
      r_base         <= '0;
      r_row0         <= '0;
      r_col0         <= '0;
      r_r            <= '0;
      r_c            <= '0;
      r_img          <= '0;
      o_mem_en       <= 1'b0;
      o_mem_addr     <= '0;
      o_image_new_25 <= 1'b0;
      o_image_new_5  <= 1'b0;
      o_image_new_16 <= 1'b0;
      o_conv_done    <= 1'b0;
      o_win_valid    <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      o_image_new_25 <= 1'b0;
      o_image_new_5  <= 1'b0;
      o_image_new_16 <= 1'b0;
      o_conv_done    <= 1'b0;
      o_done         <= 1'b0;
      if (w_strb) r_img <= i_mem_rdata;

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_k5    <= ~i_mode;
            r_img_w <= i_img_w;
            r_img_h <= i_img_h;
            r_base  <= i_base_addr;
            r_row0  <= '0;
            r_col0  <= '0;
            r_r     <= '0;
            r_c     <= '0;
            o_busy  <= 1'b1;
            if (i_img_w >= w_k_in && i_img_h >= w_k_in) begin
              r_state    <= LOAD_FULL;
              o_mem_en   <= 1'b1;
              o_mem_addr <= i_base_addr;
            end else begin
              r_state <= FIN;
              o_done  <= 1'b1;
            end
          end
        end

        LOAD_FULL, LOAD_COL: begin
          if (o_mem_en) begin
            // Read issued this cycle: its strobe goes out with the data next cycle.
            if (r_state == LOAD_COL) o_image_new_5  <= 1'b1;
            else if (r_k5)           o_image_new_25 <= 1'b1;
            else                     o_image_new_16 <= 1'b1;
            if (w_last_rd) begin
              o_mem_en <= 1'b0;
            end else begin
              r_r        <= w_nr;
              r_c        <= w_nc;
              o_mem_addr <= f_addr(r_base, r_img_w, r_row0 + w_nr, r_col0 + w_nc);
            end
          end else begin
            // Last strobe is on the bus this cycle; window complete next cycle.
            r_state     <= WAIT_CONV;
            o_win_valid <= 1'b1;
          end
        end

        WAIT_CONV: begin
          if (i_win_done) begin
            o_win_valid <= 1'b0;
            r_r         <= '0;
            r_c         <= '0;
            if (w_last_col && w_last_row) begin
              r_state <= FIN;
              o_done  <= 1'b1;
            end else if (w_last_col) begin
              r_row0     <= r_row0 + DIM_W'(1);
              r_col0     <= '0;
              r_state    <= LOAD_FULL;
              o_mem_en   <= 1'b1;
              o_mem_addr <= f_addr(r_base, r_img_w, r_row0 + DIM_W'(1), '0);
            end else if (r_k5) begin
              r_col0      <= r_col0 + DIM_W'(1);
              r_state     <= SHIFT;
              o_conv_done <= 1'b1;
            end else begin
              r_col0     <= r_col0 + DIM_W'(1);
              r_state    <= LOAD_FULL;
              o_mem_en   <= 1'b1;
              o_mem_addr <= f_addr(r_base, r_img_w, r_row0, r_col0 + DIM_W'(1));
            end
          end
        end

        SHIFT: begin
          // Shift pulse is on the bus now; first column read follows, strobe a cycle later.
          r_state    <= LOAD_COL;
          r_r        <= '0;
          r_c        <= DIM_W'(4);
          o_mem_en   <= 1'b1;
          o_mem_addr <= f_addr(r_base, r_img_w, r_row0, r_col0 + DIM_W'(4));
        end

        FIN: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_feeder.sv
// Scoreboard bench for image_feeder: stimulus pushes expected reads, strobes
// and pulses into queues; a negedge monitor pops and compares them.
module tb_image_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_mode, i_win_done;
  logic [7:0]  i_img_w, i_img_h;
  logic [15:0] i_base_addr;
  logic        o_mem_en;
  logic [15:0] o_mem_addr;
  logic [7:0]  i_mem_rdata;
  logic [7:0]  o_image;
  logic        o_image_new_25, o_image_new_5, o_image_new_16;
  logic        o_conv_done, o_win_valid, o_busy, o_done;

  image_feeder #(.ADDR_W(16), .DIM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_img_w(i_img_w), .i_img_h(i_img_h), .i_base_addr(i_base_addr),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata),
    .o_image(o_image), .o_image_new_25(o_image_new_25),
    .o_image_new_5(o_image_new_5), .o_image_new_16(o_image_new_16),
    .o_conv_done(o_conv_done), .o_win_valid(o_win_valid),
    .i_win_done(i_win_done), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // SRAM contents are a fixed function of the address.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return (a[7:0] * 8'd13) ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) if (o_mem_en) i_mem_rdata <= mem_f(o_mem_addr);

  typedef struct { int kind; logic [7:0] data; } strb_t;
  localparam int EV_CONV = 1, EV_DONE = 2;

  logic [15:0] q_addr[$];
  strb_t       q_strb[$];
  int          q_ev[$];

  int errs = 0, checks = 0;
  int cyc = 0, done_cyc = 0, win_cnt = 0;
  bit mon_en = 1'b0, prev_valid = 1'b0;
  int g_w;
  logic [15:0] g_base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_rd(input int kind, input int a);
    strb_t s;
    q_addr.push_back(16'(a));
    s.kind = kind;
    s.data = mem_f(16'(a));
    q_strb.push_back(s);
  endtask

  task automatic push_win(input bit full, input int k, input int row0, input int col0);
    if (full) begin
      for (int c = 0; c < k; c++)
        for (int r = 0; r < k; r++)
          push_rd((k == 5) ? 25 : 16, g_base + (row0 + r) * g_w + col0 + c);
    end else begin
      q_ev.push_back(EV_CONV);
      for (int r = 0; r < 5; r++) push_rd(5, g_base + (row0 + r) * g_w + col0 + 4);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      int n;
      int kind;
      if (o_mem_en) begin
        if (q_addr.size() == 0) chk(0, "unexpected_read", o_mem_addr, -1);
        else begin
          logic [15:0] ea;
          ea = q_addr.pop_front();
          chk(o_mem_addr == ea, "read_addr", o_mem_addr, ea);
        end
      end
      n = o_image_new_25 + o_image_new_5 + o_image_new_16 + o_conv_done;
      if (n != 0) chk(n == 1, "strobe_exclusive", n, 1);
      if (o_image_new_25 | o_image_new_5 | o_image_new_16) begin
        kind = o_image_new_25 ? 25 : (o_image_new_5 ? 5 : 16);
        if (q_strb.size() == 0) chk(0, "unexpected_strobe", kind, 0);
        else begin
          strb_t s;
          s = q_strb.pop_front();
          chk(kind == s.kind, "strobe_kind", kind, s.kind);
          chk(o_image == s.data, "pixel_data", o_image, s.data);
        end
      end
      if (o_conv_done) begin
        if (q_ev.size() == 0) chk(0, "unexpected_conv_done", 1, 0);
        else chk(q_ev.pop_front() == EV_CONV, "conv_done_order", EV_CONV, EV_DONE);
      end
      if (o_done) begin
        done_cyc = cyc;
        if (q_ev.size() == 0) chk(0, "unexpected_done", 1, 0);
        else chk(q_ev.pop_front() == EV_DONE, "done_order", EV_DONE, EV_CONV);
      end
      if (o_win_valid && !prev_valid) win_cnt++;
      prev_valid = o_win_valid;
    end
  end

  task automatic wait_valid(output int at);
    int n;
    n = 0;
    at = -1;
    while (!o_win_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (o_win_valid) at = cyc;
    else chk(0, "win_valid_timeout", n, 300);
  endtask

  task automatic run_frame(input logic mode, input int w, input int h, input int base,
                           input int exp_wins, input int hold, input bit spurious,
                           input bit start_in_wait, input int exp_lat);
    int k, st, at, lowc, w0, n;
    k = mode ? 4 : 5;
    g_w = w;
    g_base = 16'(base);
    i_mode = mode; i_img_w = 8'(w); i_img_h = 8'(h); i_base_addr = 16'(base);
    w0 = win_cnt;
    if (w >= k && h >= k) push_win(1, k, 0, 0);
    else q_ev.push_back(EV_DONE);
    @(negedge clk); i_start = 1'b1; st = cyc;
    @(negedge clk); i_start = 1'b0;
    if (spurious) begin
      repeat (4) @(negedge clk);
      i_win_done = 1'b1;
      @(negedge clk); i_win_done = 1'b0;
    end
    if (w >= k && h >= k) begin
      for (int row = 0; row <= h - k; row++)
        for (int col = 0; col <= w - k; col++) begin
          wait_valid(at);
          if (row == 0 && col == 0) begin
            chk(at - st == exp_lat, "first_win_latency", at - st, exp_lat);
            if (hold > 0) begin
              lowc = 0;
              repeat (hold) begin
                @(negedge clk);
                if (!o_win_valid) lowc++;
              end
              chk(lowc == 0, "win_valid_held", lowc, 0);
            end
            if (start_in_wait) begin
              i_mode = ~mode; i_img_w = 8'(w + 3); i_img_h = 8'(h + 3); i_base_addr = 16'h0;
              i_start = 1'b1;
              @(negedge clk); i_start = 1'b0;
              i_mode = mode; i_img_w = 8'(w); i_img_h = 8'(h); i_base_addr = 16'(base);
            end
          end
          if (row == h - k && col == w - k) q_ev.push_back(EV_DONE);
          else if (col == w - k)            push_win(1, k, row + 1, 0);
          else if (k == 5)                  push_win(0, k, row, col + 1);
          else                              push_win(1, k, row, col + 1);
          i_win_done = 1'b1;
          @(negedge clk); i_win_done = 1'b0;
          chk(!o_win_valid, "win_valid_drop", o_win_valid, 0);
        end
    end
    n = 0;
    while ((o_busy || q_ev.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (w < k || h < k) chk(done_cyc - st == 1, "done_latency", done_cyc - st, 1);
    chk(q_ev.size() == 0 && q_addr.size() == 0 && q_strb.size() == 0,
        "queues_drained", q_ev.size() + q_addr.size() + q_strb.size(), 0);
    chk(o_busy == 1'b0, "busy_after_done", o_busy, 0);
    chk(win_cnt - w0 == exp_wins, "window_count", win_cnt - w0, exp_wins);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_win_done = 1'b0;
    i_img_w = '0; i_img_h = '0; i_base_addr = '0;
    repeat (3) @(negedge clk);
    chk({o_mem_en, o_mem_addr, o_image, o_image_new_25, o_image_new_5, o_image_new_16,
         o_conv_done, o_win_valid, o_busy, o_done} == '0, "reset_outputs", o_busy, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 5x5 on 6x5: one full load, one column reload
    run_frame(1'b0, 6, 5, 16'h100, 2, 0, 1'b0, 1'b0, 27);
    // 4x4 on 5x5 with delayed handshake and a spurious i_win_done during loading
    run_frame(1'b1, 5, 5, 0, 4, 50, 1'b1, 1'b0, 18);
    // image narrower than the kernel: straight to FIN
    run_frame(1'b0, 4, 8, 16'h40, 0, 0, 1'b0, 1'b0, 0);

    // Reset in cycle 10 of LOAD_FULL
    g_w = 6; g_base = 16'h100;
    i_mode = 1'b0; i_img_w = 8'd6; i_img_h = 8'd5; i_base_addr = 16'h100;
    push_win(1, 5, 0, 0);
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (9) @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk({o_mem_en, o_mem_addr, o_image, o_image_new_25, o_image_new_5, o_image_new_16,
         o_conv_done, o_win_valid, o_busy, o_done} == '0, "midop_reset_outputs",
        {o_mem_en, o_image_new_25, o_busy}, 0);
    q_addr.delete(); q_strb.delete(); q_ev.delete();
    prev_valid = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(1'b0, 6, 5, 16'h100, 2, 0, 1'b0, 1'b0, 27);

    // i_start during WAIT_CONV must be ignored
    run_frame(1'b0, 6, 5, 16'h100, 2, 0, 1'b0, 1'b1, 27);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1);
  end

endmodule
